alarm_keypad_set: RTL

ALARM_KEYPAD_SET -- requirements
Module: alarm_keypad_set

---
 rtl/alarm_keypad_set_pkg.sv | 43 ++++
 rtl/alarm_keypad_set_if.sv | 18 +
 rtl/alarm_keypad_set_keypad_scan.sv | 117 +++++++++++
 rtl/alarm_keypad_set.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alarm_keypad_set_pkg.sv
// Shared definitions for the alarm keypad entry block: key codes, keypad
// layout and the entry FSM state type.
package alarm_keypad_set_pkg;

   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Entry {row,col} lives at nibble row*4+col; row0 is "1 2 3 A", col0 leftmost.
   localparam logic [63:0] KEY_LAYOUT = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   localparam logic [3:0] FIELD_H1   = 4'b1000;
   localparam logic [3:0] FIELD_H0   = 4'b0100;
   localparam logic [3:0] FIELD_M1   = 4'b0010;
   localparam logic [3:0] FIELD_M0   = 4'b0001;
   localparam logic [3:0] FIELD_NONE = 4'b0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_H1,
      ST_H0,
      ST_M1,
      ST_M0,
      ST_CONFIRM
   } entry_state_t;

   function automatic logic [3:0] layout_code(input logic [1:0] row, input logic [1:0] col);
      return KEY_LAYOUT[{row, col, 2'b00} +: 4];
   endfunction

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/alarm_keypad_set_if.sv
// Committed alarm setting and entry status as seen by the alarm comparator
// and display logic.
interface alarm_keypad_set_if;
   logic [7:0] Set_Hr;
   logic [7:0] Set_Min;
   logic       set_stb;
   logic       editing;
   logic [3:0] edit_field;
   logic       key_err;

   modport master (
      output Set_Hr, Set_Min, set_stb, editing, edit_field, key_err
   );

   modport slave (
      input  Set_Hr, Set_Min, set_stb, editing, edit_field, key_err
   );
endinterface

// File: rtl/alarm_keypad_set_keypad_scan.sv
// Row scanner, column synchronizer and frame debouncer for a 4x4 keypad;
// emits a single registered event per accepted press.
module keypad_scan
   import alarm_keypad_set_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int DEB_FRAMES = 4
) (
   input  logic       CLK_50,
   input  logic       CR,
   input  logic [3:0] KEY_COL,
   output logic [3:0] KEY_ROW,
   output logic       key_evt,
   output logic [3:0] key_code
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEB_FRAMES + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_N     = DW'(DEB_FRAMES);

   logic [3:0]    col_meta;
   logic [3:0]    col_sync;
   logic [SW-1:0] slot_cnt;
   logic [1:0]    row_idx;
   logic [1:0]    acc_hits;
   logic [3:0]    acc_code;
   logic          last_valid;
   logic [3:0]    last_code;
   logic [DW-1:0] deb_cnt;
   logic          pressed;

   logic          slot_end;
   logic          frame_end;
   logic [3:0]    press;
   logic          row_multi;
   logic [1:0]    col_idx;
   logic [1:0]    hits_nxt;
   logic [3:0]    code_nxt;
   logic          frame_valid;
   logic          same;
   logic [DW-1:0] cnt_nxt;

   assign KEY_ROW   = ~(4'b0001 << row_idx);
   assign slot_end  = (slot_cnt == SLOT_LAST);
   assign frame_end = slot_end && (row_idx == 2'd3);
   assign press     = ~col_sync;
   assign row_multi = (press & (press - 4'd1)) != 4'd0;
   assign col_idx   = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;

   // hits saturates at 2: anything beyond one key in a frame is "none"
   always_comb begin
      hits_nxt = acc_hits;
      code_nxt = acc_code;
      if (row_multi) begin
         hits_nxt = 2'd2;
      end else if (|press) begin
         if (acc_hits == 2'd0) begin
            hits_nxt = 2'd1;
            code_nxt = layout_code(row_idx, col_idx);
         end else begin
            hits_nxt = 2'd2;
         end
      end
   end

   assign frame_valid = (hits_nxt == 2'd1);
   assign same        = (frame_valid == last_valid) && (!frame_valid || (code_nxt == last_code));
   assign cnt_nxt     = !same ? DW'(1) : ((deb_cnt == DEB_N) ? deb_cnt : deb_cnt + 1'b1);

   always_ff @(posedge CLK_50) begin
      if (CR) begin
         col_meta   <= 4'hF;
         col_sync   <= 4'hF;
         slot_cnt   <= '0;
         row_idx    <= 2'd0;
         acc_hits   <= 2'd0;
         acc_code   <= 4'd0;
         last_valid <= 1'b0;
         last_code  <= 4'd0;
         deb_cnt    <= '0;
         pressed    <= 1'b0;
         key_evt    <= 1'b0;
         key_code   <= 4'd0;
      end else begin
         col_meta <= KEY_COL;
         col_sync <= col_meta;
         key_evt  <= 1'b0;
         if (slot_end) begin
            slot_cnt <= '0;
            row_idx  <= row_idx + 2'd1;
            if (frame_end) begin
               acc_hits   <= 2'd0;
               acc_code   <= 4'd0;
               last_valid <= frame_valid;
               last_code  <= code_nxt;
               deb_cnt    <= cnt_nxt;
               if (cnt_nxt == DEB_N) begin
                  if (!pressed && frame_valid) begin
                     key_evt  <= 1'b1;
                     key_code <= code_nxt;
                     pressed  <= 1'b1;
                  end else if (pressed && !frame_valid) begin
                     pressed  <= 1'b0;
                  end
               end
            end else begin
               acc_hits <= hits_nxt;
               acc_code <= code_nxt;
            end
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alarm_keypad_set.sv
// Alarm time entry from a 4x4 keypad: HH:MM is keyed into shadow digits and
// committed to Set_Hr/Set_Min only on confirmation.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_IDLE    | no entry in progress, only 'A' is honoured
//   ST_H1      | waiting for hour tens (0-2)
//   ST_H0      | waiting for hour units (0-9, 0-3 after 2)
//   ST_M1      | waiting for minute tens (0-5)
//   ST_M0      | waiting for minute units (0-9)
//   ST_CONFIRM | all digits in, '#' commits
module alarm_keypad_set
   import alarm_keypad_set_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int DEB_FRAMES = 4
) (
   input  logic                 CLK_50,
   input  logic                 CR,
   input  logic [3:0]           KEY_COL,
   output logic [3:0]           KEY_ROW,
   alarm_keypad_set_if.master   alarm
);

   logic         key_evt;
   logic [3:0]   key_code;

   entry_state_t state,    state_nxt;
   logic [3:0]   h1,       h1_nxt;
   logic [3:0]   h0,       h0_nxt;
   logic [3:0]   m1,       m1_nxt;
   logic [3:0]   m0,       m0_nxt;
   logic [7:0]   set_hr,   set_hr_nxt;
   logic [7:0]   set_min,  set_min_nxt;
   logic         stb,      stb_nxt;
   logic         err,      err_nxt;
   logic         editing,  editing_nxt;
   logic [3:0]   field,    field_nxt;
   logic [3:0]   limit;
   logic         in_field;

   keypad_scan #(
      .SCAN_DIV   (SCAN_DIV),
      .DEB_FRAMES (DEB_FRAMES)
   ) u_scan (
      .CLK_50   (CLK_50),
      .CR       (CR),
      .KEY_COL  (KEY_COL),
      .KEY_ROW  (KEY_ROW),
      .key_evt  (key_evt),
      .key_code (key_code)
   );

   always_ff @(posedge CLK_50) begin
      if (CR) begin
         state   <= ST_IDLE;
         h1      <= 4'd0;
         h0      <= 4'd0;
         m1      <= 4'd0;
         m0      <= 4'd0;
         set_hr  <= 8'h00;
         set_min <= 8'h00;
         stb     <= 1'b0;
         err     <= 1'b0;
         editing <= 1'b0;
         field   <= FIELD_NONE;
      end else begin
         state   <= state_nxt;
         h1      <= h1_nxt;
         h0      <= h0_nxt;
         m1      <= m1_nxt;
         m0      <= m0_nxt;
         set_hr  <= set_hr_nxt;
         set_min <= set_min_nxt;
         stb     <= stb_nxt;
         err     <= err_nxt;
         editing <= editing_nxt;
         field   <= field_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      h1_nxt      = h1;
      h0_nxt      = h0;
      m1_nxt      = m1;
      m0_nxt      = m0;
      set_hr_nxt  = set_hr;
      set_min_nxt = set_min;
      stb_nxt     = 1'b0;
      err_nxt     = 1'b0;
      in_field    = 1'b0;
      limit       = 4'd0;

      case (state)
         ST_H1:   begin in_field = 1'b1; limit = 4'd2; end
         ST_H0:   begin in_field = 1'b1; limit = (h1 == 4'd2) ? 4'd3 : 4'd9; end
         ST_M1:   begin in_field = 1'b1; limit = 4'd5; end
         ST_M0:   begin in_field = 1'b1; limit = 4'd9; end
         default: ;
      endcase

      if (key_evt) begin
         if (key_code == KEY_A) begin
            h1_nxt    = 4'd0;
            h0_nxt    = 4'd0;
            m1_nxt    = 4'd0;
            m0_nxt    = 4'd0;
            state_nxt = ST_H1;
         end else if (state != ST_IDLE && key_code == KEY_STAR) begin
            state_nxt = ST_IDLE;
         end else if (in_field && is_digit(key_code)) begin
            if (key_code <= limit) begin
               case (state)
                  ST_H1:   begin h1_nxt = key_code; state_nxt = ST_H0;      end
                  ST_H0:   begin h0_nxt = key_code; state_nxt = ST_M1;      end
                  ST_M1:   begin m1_nxt = key_code; state_nxt = ST_M0;      end
                  default: begin m0_nxt = key_code; state_nxt = ST_CONFIRM; end
               endcase
            end else begin
               err_nxt = 1'b1;
            end
         end else if (state == ST_CONFIRM && key_code == KEY_HASH) begin
            set_hr_nxt  = {h1, h0};
            set_min_nxt = {m1, m0};
            stb_nxt     = 1'b1;
            state_nxt   = ST_IDLE;
         end
      end

      editing_nxt = (state_nxt != ST_IDLE);
      case (state_nxt)
         ST_H1:   field_nxt = FIELD_H1;
         ST_H0:   field_nxt = FIELD_H0;
         ST_M1:   field_nxt = FIELD_M1;
         ST_M0:   field_nxt = FIELD_M0;
         default: field_nxt = FIELD_NONE;
      endcase
   end

   assign alarm.Set_Hr     = set_hr;
   assign alarm.Set_Min    = set_min;
   assign alarm.set_stb    = stb;
   assign alarm.key_err    = err;
   assign alarm.editing    = editing;
   assign alarm.edit_field = field;

endmodule
